// File: rtl/hall_slice_sequencer.sv
// hall_slice_sequencer
//   Turns the raw hall-effect index sensor into the display's angular
//   timebase. The sensor is synchronised and debounced, the rotation period
//   is measured in clk cycles, and NSLICES evenly spaced slice ticks are
//   emitted per revolution. A Bresenham-style accumulator spaces the ticks
//   so that no divider is needed.
//
// Ports
//   clk          system clock
//   nrst         asynchronous active-low reset
//   hall_in      raw asynchronous sensor, idle high, low while the magnet passes
//   enable       synchronous run enable; low forces IDLE on the next cycle
//   slice_tick   one-cycle pulse at the start of each slice
//   slice_idx    current slice number, 0..NSLICES-1 (saturates at NSLICES-1)
//   period       last measured revolution period in clk cycles
//   period_valid period is valid and ticks are being generated
//   stalled      period counter saturated; cleared by the next index event
//   state_dbg    current FSM state (IDLE=0, ACQUIRE=1, MEASURE=2, RUN=3)
//
// There is no valid/ready handshake on this block: slice_tick is a
// fire-and-forget strobe that the frame scheduler must sample every cycle.
module hall_slice_sequencer #(
    parameter int DEBOUNCE = 16,
    parameter int NSLICES  = 256,
    parameter int SLICE_W  = 8,
    parameter int CNT_W    = 24
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               hall_in,
    input  logic               enable,
    output logic               slice_tick,
    output logic [SLICE_W-1:0] slice_idx,
    output logic [CNT_W-1:0]   period,
    output logic               period_valid,
    output logic               stalled,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    localparam int                 DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [SLICE_W-1:0] IDX_LAST = SLICE_W'(NSLICES - 1);
    localparam logic [CNT_W:0]     NSL_EXT  = (CNT_W + 1)'(NSLICES);

    logic [2:0]         sync_q, sync_d;
    logic               deb_q, deb_d;
    logic               deb_prev_q, deb_prev_d;
    logic [DB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     acc_q, acc_d;
    logic [1:0]         state_q, state_d;
    logic               tick_q, tick_d;
    logic [SLICE_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               stalled_q, stalled_d;

    logic               index_ev;
    logic               sat;
    logic [CNT_W:0]     acc_sum;
    logic [CNT_W:0]     period_ext;

    // Synchroniser and debouncer. The counter only runs while the
    // synchronised input disagrees with the debounced level, so any
    // excursion shorter than DEBOUNCE cycles is discarded.
    always_comb begin
        sync_d     = {sync_q[1:0], hall_in};
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        if (sync_q[2] != deb_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_d = sync_q[2];
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Magnet arrival is the falling edge of the debounced level.
    assign index_ev = deb_prev_q & ~deb_q;
    assign sat      = (cnt_q == CNT_MAX);

    // Period counter: cycles since the last index event, saturating.
    always_comb begin
        if (index_ev) begin
            cnt_d = '0;
        end else if (sat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign acc_sum    = acc_q + NSL_EXT;
    assign period_ext = {1'b0, period_q};

    always_comb begin
        state_d   = state_q;
        tick_d    = 1'b0;
        idx_d     = idx_q;
        acc_d     = acc_q;
        period_d  = period_q;
        valid_d   = valid_q;
        stalled_d = stalled_q;
        if (!enable) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            acc_d     = '0;
            valid_d   = 1'b0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (index_ev) begin
                        state_d   = S_MEASURE;
                        stalled_d = 1'b0;
                    end else if (sat) begin
                        stalled_d = 1'b1;
                    end
                end
                default: begin // S_MEASURE, S_RUN
                    if (index_ev && sat) begin
                        // The saturated count is meaningless as a period, so
                        // this event only restarts the measurement.
                        state_d   = S_MEASURE;
                        valid_d   = 1'b0;
                        stalled_d = 1'b0;
                    end else if (index_ev) begin
                        // Period counts edges between events: cnt restarted
                        // at 0 one cycle after the previous event.
                        period_d = cnt_q + 1'b1;
                        state_d  = S_RUN;
                        tick_d   = 1'b1;
                        idx_d    = '0;
                        acc_d    = '0;
                        valid_d  = 1'b1;
                    end else if (sat) begin
                        state_d   = S_ACQUIRE;
                        valid_d   = 1'b0;
                        stalled_d = 1'b1;
                    end else if (state_q == S_RUN) begin
                        // Add NSLICES per cycle; each time the sum passes the
                        // period one slice has elapsed. The index never wraps:
                        // only an index event returns it to slice 0.
                        if (idx_q != IDX_LAST) begin
                            if (acc_sum >= period_ext) begin
                                acc_d  = acc_sum - period_ext;
                                idx_d  = idx_q + 1'b1;
                                tick_d = 1'b1;
                            end else begin
                                acc_d = acc_sum;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q     <= 3'b111;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            deb_cnt_q  <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            state_q    <= S_IDLE;
            tick_q     <= 1'b0;
            idx_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            deb_cnt_q  <= deb_cnt_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stalled_q  <= stalled_d;
        end
    end

    assign slice_tick   = tick_q;
    assign slice_idx    = idx_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_hall_slice_sequencer.sv
// Bench for hall_slice_sequencer with a reduced configuration (64 slices,
// 12-bit period counter) so that a stall is reached in a few thousand cycles.
// Each revolution's tick train is predicted from the driven pulse spacing:
// tick k of a revolution lands ceil(k*P/N) cycles after that revolution's
// slice-0 tick, where P is the previously measured period, and only ticks
// that land before the next index event are expected.
module tb_hall_slice_sequencer;

    localparam int DB = 16;
    localparam int NS = 64;
    localparam int SW = 6;
    localparam int CW = 12;
    localparam int BIG = 100000;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic          clk = 1'b0;
    logic          nrst;
    logic          hall_in;
    logic          enable;
    logic          slice_tick;
    logic [SW-1:0] slice_idx;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          stalled;
    logic [1:0]    state_dbg;

    hall_slice_sequencer #(
        .DEBOUNCE(DB), .NSLICES(NS), .SLICE_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .nrst(nrst), .hall_in(hall_in), .enable(enable),
        .slice_tick(slice_tick), .slice_idx(slice_idx), .period(period),
        .period_valid(period_valid), .stalled(stalled), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Entry: {gap_valid, gap[15:0], period[11:0], idx[5:0]}
    logic [34:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tick = 0;
    int last_off = 0;
    int prev_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every observed tick is matched against the next expectation.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (slice_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tick_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_idx", 32'(slice_idx), 32'(e[5:0]));
                    check("tick_period", 32'(period), 32'(e[17:6]));
                    check("tick_valid", 32'(period_valid), 1);
                    if (e[34]) check("tick_gap", 32'(cyc - last_tick), 32'(e[33:18]));
                end
                last_tick = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Magnet pass: 50 low cycles; the next falling edge follows 'gap' cycles
    // after this one.
    task automatic pulse(input int gap);
        hall_in = 1'b0;
        step(50);
        hall_in = 1'b1;
        step(gap - 50);
    endtask

    // Expected ticks of one revolution measured with period p and lasting
    // l cycles until the next index event.
    task automatic push_rev(input int p, input int l, input bit first);
        int o;
        int last;
        exp_q.push_back({~first, 16'(first ? 0 : prev_len - last_off), 12'(p), 6'd0});
        last = 0;
        for (int k = 1; k < NS; k++) begin
            o = (k * p + NS - 1) / NS;
            if (o >= l) break;
            exp_q.push_back({1'b1, 16'(o - last), 12'(p), 6'(k)});
            last = o;
        end
        last_off = last;
        prev_len = l;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        nrst    = 1'b0;
        hall_in = 1'b1;
        enable  = 1'b0;
        step(3);
        check("rst_tick", 32'(slice_tick), 0);
        check("rst_idx", 32'(slice_idx), 0);
        check("rst_period", 32'(period), 0);
        check("rst_valid", 32'(period_valid), 0);
        check("rst_stalled", 32'(stalled), 0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        nrst = 1'b1;
        step(5);
        check("idle_no_enable", 32'(state_dbg), 32'(S_IDLE));
        enable = 1'b1;
        step(2);
        check("acquire", 32'(state_dbg), 32'(S_ACQUIRE));

        // Short glitches must not produce an index event.
        for (int g = 0; g < 3; g++) begin
            hall_in = 1'b0;
            step(10);
            hall_in = 1'b1;
            step(40 + $urandom_range(0, 20));
        end
        check("glitch_state", 32'(state_dbg), 32'(S_ACQUIRE));
        check("glitch_valid", 32'(period_valid), 0);

        // Steady rotation, then speed-up, then slow-down.
        pulse(2000);
        check("measure_state", 32'(state_dbg), 32'(S_MEASURE));
        check("measure_valid", 32'(period_valid), 0);
        push_rev(2000, 2000, 1'b1);
        pulse(2000);
        check("run_state", 32'(state_dbg), 32'(S_RUN));
        check("run_period", 32'(period), 2000);
        check("run_valid", 32'(period_valid), 1);
        push_rev(2000, 2000, 1'b0);
        pulse(2000);
        push_rev(2000, 1600, 1'b0);
        pulse(1600);
        check("speedup_period", 32'(period), 2000);
        push_rev(1600, 2400, 1'b0);
        pulse(2400);
        check("slow_idx_hold", 32'(slice_idx), NS - 1);
        check("slow_period", 32'(period), 1600);
        push_rev(2400, 2400, 1'b0);
        pulse(2400);
        check("period_2400", 32'(period), 2400);

        // Sensor stops: counter saturates.
        push_rev(2400, BIG, 1'b0);
        pulse(2400);
        waited = 0;
        while (stalled !== 1'b1 && waited < 4000) begin
            step(1);
            waited++;
        end
        check("stall_seen", 32'(stalled), 1);
        check("stall_valid", 32'(period_valid), 0);
        check("stall_state", 32'(state_dbg), 32'(S_ACQUIRE));
        check("stall_q_empty", 32'(exp_q.size()), 0);
        step(100);

        // Resume.
        pulse(2000);
        check("resume_stalled", 32'(stalled), 0);
        check("resume_state", 32'(state_dbg), 32'(S_MEASURE));
        check("resume_valid", 32'(period_valid), 0);
        push_rev(2000, BIG, 1'b1);
        pulse(2200);
        check("resume_run", 32'(state_dbg), 32'(S_RUN));
        check("resume_idx_sat", 32'(slice_idx), NS - 1);
        check("resume_period", 32'(period), 2000);
        check("resume_q_empty", 32'(exp_q.size()), 0);

        // Enable dropped.
        enable = 1'b0;
        step(1);
        check("dis_state", 32'(state_dbg), 32'(S_IDLE));
        check("dis_idx", 32'(slice_idx), 0);
        check("dis_valid", 32'(period_valid), 0);
        check("dis_period_held", 32'(period), 2000);
        enable = 1'b1;
        step(1);
        check("reen_state", 32'(state_dbg), 32'(S_ACQUIRE));
        pulse(2000);
        check("reen_measure", 32'(state_dbg), 32'(S_MEASURE));
        push_rev(2000, BIG, 1'b1);
        pulse(1000);
        check("reen_run", 32'(state_dbg), 32'(S_RUN));
        check("reen_valid", 32'(period_valid), 1);

        // Asynchronous reset while a tick is high.
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (slice_tick !== 1'b1 && waited < 100);
        check("tick_before_reset", 32'(slice_tick), 1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_tick", 32'(slice_tick), 0);
        check("arst_idx", 32'(slice_idx), 0);
        check("arst_period", 32'(period), 0);
        check("arst_valid", 32'(period_valid), 0);
        check("arst_stalled", 32'(stalled), 0);
        check("arst_state", 32'(state_dbg), 32'(S_IDLE));
        exp_q.delete();
        step(3);
        nrst = 1'b1;
        step(2);
        check("post_rst_acquire", 32'(state_dbg), 32'(S_ACQUIRE));
        step(200);
        check("no_spurious_event", 32'(state_dbg), 32'(S_ACQUIRE));
        check("post_rst_valid", 32'(period_valid), 0);
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
